// File: rtl/cell_tt_pkg.sv
// Shared definitions for the cell truth-table reader.
//   tt_state_t : reader FSM states
//   SETTLE_MIN : smallest legal settle time in cycles
//   nvec()     : number of stimulus vectors for a given input count
package cell_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } tt_state_t;

    localparam int SETTLE_MIN = 1;

    function automatic int nvec(input int nin);
        return 1 << nin;
    endfunction

endpackage : cell_tt_pkg

// File: rtl/cell_tt_settle_cnt.sv
// Loadable down-counter with a zero flag, used to time the settle wait.
// Ports:
//   clk      : clock
//   clr      : synchronous active-low reset (count -> 0)
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   zero     : count is zero
module cell_tt_settle_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule : cell_tt_settle_cnt

// File: rtl/cell_tt_reader.sv
// Sequential truth-table reader. On start it drives every input vector in
// ascending order, waits SETTLE cycles after each stimulus change, samples the
// cell response and assembles the complete truth table.
// Optional feature macro: CELL_TT_CHECK_EN (compare against an expected table).
// Ports:
//   clk          : clock, rising edge
//   clr          : synchronous active-low reset
//   start        : one-cycle request, accepted only in IDLE
//   stim         : registered stimulus to the cell under test
//   cell_out     : response of the cell under test
//   busy         : run in progress (excludes the done cycle)
//   done         : one-cycle completion pulse
//   tt           : truth table, tt[v] = response to stimulus v
//   exp_tt       : expected table (CELL_TT_CHECK_EN only)
//   mismatch_cnt : differing entries (CELL_TT_CHECK_EN only)
//   pass         : table matched at done (CELL_TT_CHECK_EN only)
module cell_tt_reader
    import cell_tt_pkg::*;
#(
    parameter int NIN    = 8,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    output logic [NIN-1:0]        stim,
    input  logic                  cell_out,
    output logic                  busy,
    output logic                  done,
    output logic [nvec(NIN)-1:0]  tt
`ifdef CELL_TT_CHECK_EN
    ,
    input  logic [nvec(NIN)-1:0]  exp_tt,
    output logic [NIN:0]          mismatch_cnt,
    output logic                  pass
`endif
);

    // Settle times below the minimum are clamped rather than producing a
    // zero-cycle wait that would sample before the cell responds.
    localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
    localparam int CW         = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CW-1:0]  RELOAD    = CW'(SETTLE_EFF - 1);
    localparam logic [NIN-1:0] LAST_VEC  = '1;

    tt_state_t state;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;
    logic      last_vec;

    assign last_vec = (stim == LAST_VEC);

    // The counter is reloaded when a run starts and when moving to the next
    // vector, so every vector gets the same SETTLE-cycle wait.
    assign cnt_load = ((state == ST_IDLE) && start) ||
                      ((state == ST_SAMPLE) && !last_vec);
    assign cnt_dec  = (state == ST_SETTLE) && !cnt_zero;

    cell_tt_settle_cnt #(
        .W (CW)
    ) u_settle_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= ST_IDLE;
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            // NOTE: the table is a plain flop vector, not a RAM, so clearing it
            // on reset is cheap and discards any partial results.
            tt    <= '0;
`ifdef CELL_TT_CHECK_EN
            mismatch_cnt <= '0;
            pass         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stim  <= '0;
                        busy  <= 1'b1;
                        state <= ST_SETTLE;
`ifdef CELL_TT_CHECK_EN
                        mismatch_cnt <= '0;
                        pass         <= 1'b0;
`endif
                    end
                end

                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    tt[stim] <= cell_out;
`ifdef CELL_TT_CHECK_EN
                    if (cell_out != exp_tt[stim]) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    end
`endif
                    if (last_vec) begin
                        // busy drops exactly as done rises; stim holds all-ones.
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    // start is not looked at here; it is only accepted from IDLE.
                    state <= ST_IDLE;
`ifdef CELL_TT_CHECK_EN
                    pass <= (mismatch_cnt == '0);
`endif
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : cell_tt_reader

// File: tb/tb_cell_tt_reader.sv
// Self-checking bench for cell_tt_reader. Three instances:
//   u_and2 : NIN=2, SETTLE=1, combinational cell driven by the bench per cycle
//   u_c2   : NIN=8, SETTLE=1, C2-style mux cell
//   u_s2   : NIN=3, SETTLE=2, registered cell with a random function
// Cycle 0 is the cycle in which start is presented; outputs are sampled on the
// falling edge of each cycle.
module tb_cell_tt_reader;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- AND2 / random 2-input instance ----------------
    logic       start2 = 1'b0;
    logic       cell2  = 1'b0;
    logic [3:0] fn2    = 4'b1000;
    logic [1:0] stim2;
    logic       busy2, done2;
    logic [3:0] tt2;

    // ---------------- C2-style instance ----------------
    logic         start8 = 1'b0;
    logic         cell8;
    logic [7:0]   stim8;
    logic         busy8, done8;
    logic [255:0] tt8;
    logic [255:0] c2_table;

    // ---------------- registered S2-style instance ----------------
    logic       starts = 1'b0;
    logic       cells  = 1'b0;
    logic [7:0] sfn    = 8'h00;
    logic [2:0] stims;
    logic       busys, dones;
    logic [7:0] tts;

`ifdef CELL_TT_CHECK_EN
    logic [3:0]   exp2 = 4'b0000;
    logic [2:0]   mm2;
    logic         pass2;
    logic [255:0] exp8 = '0;
    logic [8:0]   mm8;
    logic         pass8;
    logic [7:0]   exps = 8'h00;
    logic [3:0]   mms;
    logic         passs;
`endif

    cell_tt_reader #(.NIN(2), .SETTLE(1)) u_and2 (
        .clk (clk), .clr (clr), .start (start2), .stim (stim2),
        .cell_out (cell2), .busy (busy2), .done (done2), .tt (tt2)
`ifdef CELL_TT_CHECK_EN
        , .exp_tt (exp2), .mismatch_cnt (mm2), .pass (pass2)
`endif
    );

    cell_tt_reader #(.NIN(8), .SETTLE(1)) u_c2 (
        .clk (clk), .clr (clr), .start (start8), .stim (stim8),
        .cell_out (cell8), .busy (busy8), .done (done8), .tt (tt8)
`ifdef CELL_TT_CHECK_EN
        , .exp_tt (exp8), .mismatch_cnt (mm8), .pass (pass8)
`endif
    );

    cell_tt_reader #(.NIN(3), .SETTLE(2)) u_s2 (
        .clk (clk), .clr (clr), .start (starts), .stim (stims),
        .cell_out (cells), .busy (busys), .done (dones), .tt (tts)
`ifdef CELL_TT_CHECK_EN
        , .exp_tt (exps), .mismatch_cnt (mms), .pass (passs)
`endif
    );

    // C2 cell: stim = {D[3:0], B1, A1, B0, A0}, out = D[{A1|B1, A0&B0}]
    assign cell8 = stim8[4 + {30'd0, (stim8[2] | stim8[3]), (stim8[0] & stim8[1])}];

    // Registered cell: one flop of latency between stimulus and response.
    always @(posedge clk) cells <= sfn[stims];

    // Expected C2 truth table, built from the cell's definition.
    function automatic logic c2_ref(input int v);
        logic [3:0] d;
        logic [1:0] sel;
        logic a0, b0, a1, b1;
        a0  = v[0];
        b0  = v[1];
        a1  = v[2];
        b1  = v[3];
        d   = v[7:4];
        sel = {a1 | b1, a0 & b0};
        return d[sel];
    endfunction

    // One randomized run on the 2-input instance: random function, random
    // expected-table error mask, glitches on cell_out during every settle cycle.
    task automatic run2(input logic [3:0] f, input logic [3:0] err_mask);
        int done_cyc;
        done_cyc = -1;
        fn2 = f;
`ifdef CELL_TT_CHECK_EN
        exp2 = f ^ err_mask;
`endif
        @(negedge clk);
        start2 = 1'b1;
        cell2  = fn2[stim2];
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done2 && done_cyc < 0) done_cyc = c;
            start2 = 1'b0;
            cell2  = fn2[stim2] ^ ((c % 2 == 1) ? 1'($urandom_range(1, 0)) : 1'b0);
            if (done_cyc >= 0) break;
        end
        check("rand_done_cycle", 256'(done_cyc), 256'(9));
        check("rand_tt", 256'(tt2), 256'(f));
        @(negedge clk);
`ifdef CELL_TT_CHECK_EN
        check("rand_mismatch_cnt", 256'(mm2), 256'($countones(err_mask)));
        check("rand_pass", 256'(pass2), 256'(err_mask == 4'b0000));
`else
        if (err_mask == 4'b0000) check("rand_busy_idle", 256'(busy2), 256'(0));
`endif
    endtask

    initial begin
        int exp_stim;
        int done_count;
        int done_cyc;

        for (int v = 0; v < 256; v++) c2_table[v] = c2_ref(v);
`ifdef CELL_TT_CHECK_EN
        exp8 = c2_table;
`endif

        // ---------------- reset state ----------------
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stim", 256'(stim2), 256'(0));
        check("rst_busy", 256'(busy2), 256'(0));
        check("rst_done", 256'(done2), 256'(0));
        check("rst_tt", 256'(tt2), 256'(0));
        check("rst_tt8", tt8, 256'(0));
        check("rst_tts", 256'(tts), 256'(0));
`ifdef CELL_TT_CHECK_EN
        check("rst_mm", 256'(mm2), 256'(0));
        check("rst_pass", 256'(pass2), 256'(0));
`endif
        clr = 1'b1;
        @(negedge clk);

        // ---------------- AND2 run with ignored restarts ----------------
        // start in cycles 0, 3, 9, 10: only 0 and 10 are accepted.
        fn2 = 4'b1000;
`ifdef CELL_TT_CHECK_EN
        exp2 = 4'b1001;
`endif
        @(negedge clk);
        start2 = 1'b1;
        cell2  = fn2[stim2];
        done_count = 0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c <= 8)       exp_stim = (c - 1) / 2;
            else if (c <= 10) exp_stim = 3;
            else if (c <= 18) exp_stim = (c - 11) / 2;
            else              exp_stim = 3;
            check($sformatf("and2_stim_c%0d", c), 256'(stim2), 256'(exp_stim));
            check($sformatf("and2_busy_c%0d", c), 256'(busy2),
                  256'(((c >= 1) && (c <= 8)) || ((c >= 11) && (c <= 18))));
            check($sformatf("and2_done_c%0d", c), 256'(done2), 256'((c == 9) || (c == 19)));
            if (done2) done_count++;
            if (c == 10) begin
                check("and2_tt_run1", 256'(tt2), 256'(4'b1000));
`ifdef CELL_TT_CHECK_EN
                check("and2_mm_1001", 256'(mm2), 256'(1));
                check("and2_pass_1001", 256'(pass2), 256'(0));
                exp2 = 4'b1000;
`endif
            end
            start2 = ((c == 3) || (c == 9) || (c == 10));
            cell2  = fn2[stim2] ^ ((c % 2 == 1) ? 1'($urandom_range(1, 0)) : 1'b0);
        end
        check("and2_done_count", 256'(done_count), 256'(2));
        check("and2_tt_run2", 256'(tt2), 256'(4'b1000));
`ifdef CELL_TT_CHECK_EN
        check("and2_mm_1000", 256'(mm2), 256'(0));
        check("and2_pass_1000", 256'(pass2), 256'(1));
`endif

        // ---------------- randomized 2-input runs ----------------
        for (int r = 0; r < 6; r++) begin
            run2(4'($urandom), (r % 2 == 0) ? 4'b0000 : 4'($urandom));
        end

        // ---------------- reset mid-run ----------------
        fn2 = 4'b1111;
        @(negedge clk);
        start2 = 1'b1;
        cell2  = fn2[stim2];
        done_count = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (c == 6) begin
                check("clr_stim", 256'(stim2), 256'(0));
                check("clr_tt", 256'(tt2), 256'(0));
                check("clr_busy", 256'(busy2), 256'(0));
            end
            if (done2) done_count++;
            clr   = (c == 5) ? 1'b0 : 1'b1;
            cell2 = fn2[stim2];
        end
        check("clr_no_done", 256'(done_count), 256'(0));

        // ---------------- C2-style cell, NIN=8 ----------------
        done_cyc = -1;
        @(negedge clk);
        start8 = 1'b1;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                done_cyc = c;
                check("c2_busy_at_done", 256'(busy8), 256'(0));
                break;
            end
        end
        check("c2_done_cycle", 256'(done_cyc), 256'(513));
        for (int d = 0; d < 16; d++) begin
            check($sformatf("c2_tt_d%0d", d), 256'(tt8[d*16 +: 16]), 256'(c2_table[d*16 +: 16]));
        end
        check("c2_stim_hold", 256'(stim8), 256'(255));
`ifdef CELL_TT_CHECK_EN
        @(negedge clk);
        check("c2_pass", 256'(pass8), 256'(1));
`endif

        // ---------------- registered cell, SETTLE=2 ----------------
        for (int r = 0; r < 3; r++) begin
            sfn = 8'($urandom);
`ifdef CELL_TT_CHECK_EN
            exps = sfn;
`endif
            done_cyc = -1;
            @(negedge clk);
            starts = 1'b1;
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                starts = 1'b0;
                if (dones) begin
                    done_cyc = c;
                    break;
                end
            end
            check($sformatf("s2_done_cycle_r%0d", r), 256'(done_cyc), 256'(3 * 8 + 1));
            check($sformatf("s2_tt_r%0d", r), 256'(tts), 256'(sfn));
            @(negedge clk);
`ifdef CELL_TT_CHECK_EN
            check($sformatf("s2_pass_r%0d", r), 256'(passs), 256'(1));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cell_tt_reader

// File: doc/cell_tt_reader.md
# cell_tt_reader

Sequential truth-table reader for the logic-module cells (C1/C2-style combinational cells and S-style registered cells). On `start` it drives every input combination, waits for the cell to settle, samples the cell output and builds a complete truth table. The cells only consume stimulus; this block produces it and reads the responses back. It sits in the characterisation and self-test path beside the cell library.

## Interface
Parameters:
- `NIN`, 8: number of cell inputs driven; the block reads 2^NIN vectors. Legal range 1..10.
- `SETTLE`, 1: cycles waited after each stimulus change before sampling. Minimum 1. Use 1 for combinational cells and 2 for S-style registered cells.

Ports:
- `clk`  in  1: single clock; all logic updates on the rising edge.
- `clr`  in  1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1: one-cycle request to begin a read. Ignored while `busy` is high.
- `stim`  out  NIN: registered stimulus to the cell under test. Bit order is decided by the bench wrapper.
- `cell_out`  in  1: response of the cell under test.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`, exclusive of the `done` cycle.
- `done`  out  1: one-cycle pulse when the table is complete.
- `tt`  out  2^NIN: truth table; `tt[v]` is the response sampled for stimulus `v`.
- `exp_tt`  in  2^NIN: expected table. Present only with `CELL_TT_CHECK_EN`.
- `mismatch_cnt`  out  NIN+1: number of differing entries. Present only with `CELL_TT_CHECK_EN`.
- `pass`  out  1: high when `mismatch_cnt` is 0 at `done`. Present only with `CELL_TT_CHECK_EN`.

## Operation
FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with `start`=1:
  - `stim`<=0 and `cnt`<=SETTLE-1.
  - Go to SETTLE.
- SETTLE:
  - If `cnt`==0, go to SAMPLE.
  - Otherwise `cnt`<=`cnt`-1.
- SAMPLE:
  - `tt[stim]`<=`cell_out`.
  - If `stim`==2^NIN-1, go to DONE.
  - Otherwise `stim`<=`stim`+1, `cnt`<=SETTLE-1, and go to SETTLE.
- DONE:
  - `done`=1 for this cycle only.
  - Return to IDLE.
- Vector order is ascending only. `stim` never wraps during a run.
- `stim` holds its last value (all ones) after the run until the next `start`.
- `tt` is fully overwritten on every run and holds its value between runs.

Boundary conditions:
- `start` while `busy`=1 or in DONE is dropped; there is no queuing.
- `start` in the DONE cycle is ignored. It is accepted only from IDLE.
- Reset mid-run:
  - Returns to IDLE on the next edge with `stim`=0.
  - `tt` is cleared to 0; partial results are discarded.
  - No `done` pulse is produced.
- `cell_out` is sampled only in SAMPLE. Glitches during SETTLE have no effect.

## Timing
- Reset values:
  - `stim`=0, `busy`=0, `done`=0, `tt`=0, state IDLE.
  - With `CELL_TT_CHECK_EN`: `mismatch_cnt`=0, `pass`=0.
- `start` accepted in cycle 0; `busy`=1 from cycle 1.
- Each vector costs SETTLE+1 cycles.
- `done` is high in cycle 2^NIN·(SETTLE+1)+1.
- `busy` falls in the same cycle that `done` rises.
- The earliest next `start` is accepted in the cycle after `done`.
- `cell_out` for vector `v` is sampled exactly SETTLE cycles after `stim` becomes `v`.

## Configuration
Macro: `CELL_TT_CHECK_EN`.
- Defined:
  - `exp_tt`, `mismatch_cnt` and `pass` exist.
  - `mismatch_cnt` is cleared when `start` is accepted.
  - In each SAMPLE cycle, `mismatch_cnt` increments when `cell_out` != `exp_tt[stim]`.
  - In the DONE cycle, `pass` <= (final count == 0).
  - `pass` holds until the next accepted `start`, which clears it.
  - `exp_tt` must be held stable for the whole run.
- Undefined:
  - These ports and all compare logic are absent.
  - Timing is identical to the defined case.

## Structure
- Shared package `cell_tt_pkg` holds:
  - the FSM state enum `tt_state_t`;
  - `SETTLE_MIN` = 1;
  - a `nvec(NIN)` helper function returning 2^NIN.
- One sub-module, `cell_tt_settle_cnt`: a loadable down-counter with a zero flag.
- The FSM, stimulus register, table and checker live in `cell_tt_reader`.

## Test plan
- AND2 cell, NIN=2, SETTLE=1, `start` in cycle 0:
  - `stim` sequence 0,1,2,3.
  - `done` in cycle 9.
  - `tt`=4'b1000.
  - `busy` high for cycles 1–8.
- C2-style cell, NIN=8, stim = {D[3:0], B1, A1, B0, A0}:
  - For every D, `tt` entries match D[{A1|B1, A0&B0}].
  - `done` in cycle 513.
- S2-style registered cell, SETTLE=2:
  - `tt` matches the combinational expectation with no off-by-one shift.
  - `done` in cycle 3·2^NIN+1.
- `start` pulsed again in cycles 3 and 9 of an AND2 run:
  - Both pulses are ignored; exactly one `done`.
  - A `start` in cycle 10 begins a second run.
- `clr`=0 in cycle 5 of an AND2 run:
  - From cycle 6: `stim`=0, `tt`=0, `busy`=0.
  - No `done` pulse.
- With `CELL_TT_CHECK_EN`, AND2 cell, `exp_tt`=4'b1001:
  - `mismatch_cnt`=1 and `pass`=0.
  - With `exp_tt`=4'b1000: `mismatch_cnt`=0 and `pass`=1.
